// File: rtl/ghost_mode_ctrl_if.sv
// Control/status bundle between the ghost mode scheduler and the game logic.
interface ghost_mode_ctrl_if;
  logic       start;
  logic       pause;
  logic       pellet;
  logic       isScatter;
  logic       isChase;
  logic       isFright;
  logic       fright_flash;
  logic       reverse;
  logic [2:0] phase;

  modport master (
    output start, pause, pellet,
    input  isScatter, isChase, isFright, fright_flash, reverse, phase
  );

  modport slave (
    input  start, pause, pellet,
    output isScatter, isChase, isFright, fright_flash, reverse, phase
  );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// Global scatter/chase/frightened scheduler shared by all ghosts; power pellets
// pre-empt the timed schedule, which resumes from its held counts afterwards.
module ghost_mode_ctrl #(
  parameter int unsigned SEC_TICKS  = 25_000_000,
  parameter int unsigned SCAT1_SEC  = 7,
  parameter int unsigned SCAT2_SEC  = 5,
  parameter int unsigned CHASE_SEC  = 20,
  parameter int unsigned FRIGHT_SEC = 6,
  parameter int unsigned FLASH_SEC  = 2
) (
  input logic              clk,
  input logic              reset_n,
  ghost_mode_ctrl_if.slave bus
);

  localparam int unsigned PRE_W   = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned PH_W    = 3;
  localparam int unsigned FR_LAST = (FRIGHT_SEC == 0) ? 0 : FRIGHT_SEC - 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SEC_TICKS - 1);
  localparam logic [PH_W-1:0]  PH_FINAL = PH_W'(7);

  typedef enum logic [1:0] {IDLE, SCATTER, CHASE, FRIGHT} state_t;

  state_t           state, stateNext;
  logic [PH_W-1:0]  phase, phaseNext;
  logic [PRE_W-1:0] schedPre, schedPreNext, frPre, frPreNext;
  logic [SEC_W-1:0] schedSec, schedSecNext, frSec, frSecNext;
  logic             revNext;
  logic             scatNext, chaseNext, frightNext, flashNext;
  logic             inSched, schedTick, phaseExpire, frTick, frExpire, pelletOk;

  function automatic logic [SEC_W-1:0] phaseDur(input logic [PH_W-1:0] ph);
    case (ph)
      3'd0, 3'd2: phaseDur = SEC_W'(SCAT1_SEC);
      3'd4, 3'd6: phaseDur = SEC_W'(SCAT2_SEC);
      default:    phaseDur = SEC_W'(CHASE_SEC);
    endcase
  endfunction

  // State and counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      phase            <= '0;
      schedPre         <= '0;
      schedSec         <= '0;
      frPre            <= '0;
      frSec            <= '0;
      bus.isScatter    <= 1'b0;
      bus.isChase      <= 1'b0;
      bus.isFright     <= 1'b0;
      bus.fright_flash <= 1'b0;
      bus.reverse      <= 1'b0;
      bus.phase        <= '0;
    end else begin
      state            <= stateNext;
      phase            <= phaseNext;
      schedPre         <= schedPreNext;
      schedSec         <= schedSecNext;
      frPre            <= frPreNext;
      frSec            <= frSecNext;
      bus.isScatter    <= scatNext;
      bus.isChase      <= chaseNext;
      bus.isFright     <= frightNext;
      bus.fright_flash <= flashNext;
      bus.reverse      <= revNext;
      bus.phase        <= phaseNext;
    end
  end

  assign inSched     = (state == SCATTER) || (state == CHASE);
  assign schedTick   = inSched && !bus.pause && (schedPre == PRE_MAX);
  assign phaseExpire = schedTick && (phase != PH_FINAL) &&
                       (schedSec == phaseDur(phase) - SEC_W'(1));
  assign frTick      = (state == FRIGHT) && !bus.pause && (frPre == PRE_MAX);
  assign frExpire    = frTick && (frSec == SEC_W'(FR_LAST));
  assign pelletOk    = bus.pellet && !bus.pause && (FRIGHT_SEC != 0) &&
                       (inSched || (state == FRIGHT));

  // Next-state and counter logic; pause freezes everything
  always_comb begin
    stateNext    = state;
    phaseNext    = phase;
    schedPreNext = schedPre;
    schedSecNext = schedSec;
    frPreNext    = frPre;
    frSecNext    = frSec;
    revNext      = 1'b0;
    if (!bus.pause) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            stateNext    = SCATTER;
            phaseNext    = '0;
            schedPreNext = '0;
            schedSecNext = '0;
            frPreNext    = '0;
            frSecNext    = '0;
          end
        end
        SCATTER, CHASE: begin
          if (phaseExpire) begin
            phaseNext    = phase + PH_W'(1);
            schedPreNext = '0;
            schedSecNext = '0;
            stateNext    = phaseNext[0] ? CHASE : SCATTER;
            revNext      = 1'b1;
          end else begin
            schedPreNext = schedTick ? '0 : schedPre + PRE_W'(1);
            // Final phase never expires, so its second count stays put
            if (schedTick && (phase != PH_FINAL)) schedSecNext = schedSec + SEC_W'(1);
          end
          if (pelletOk) begin
            stateNext = FRIGHT;
            frPreNext = '0;
            frSecNext = '0;
            revNext   = 1'b1;
          end
        end
        FRIGHT: begin
          frPreNext = frTick ? '0 : frPre + PRE_W'(1);
          if (frTick) frSecNext = frSec + SEC_W'(1);
          if (frExpire) stateNext = phase[0] ? CHASE : SCATTER;
          if (pelletOk) begin
            stateNext = FRIGHT;
            frPreNext = '0;
            frSecNext = '0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, captured by the register above
  always_comb begin
    scatNext   = 1'b0;
    chaseNext  = 1'b0;
    frightNext = 1'b0;
    flashNext  = 1'b0;
    case (stateNext)
      SCATTER: scatNext  = 1'b1;
      CHASE:   chaseNext = 1'b1;
      FRIGHT: begin
        frightNext = 1'b1;
        flashNext  = (32'(frSecNext) + FLASH_SEC) >= FRIGHT_SEC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl with a shortened schedule.
module tb_ghost_mode_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   fails;
  int   cyc;

  ghost_mode_ctrl_if bus();

  ghost_mode_ctrl #(
    .SEC_TICKS (4),
    .SCAT1_SEC (2),
    .SCAT2_SEC (1),
    .CHASE_SEC (3),
    .FRIGHT_SEC(2),
    .FLASH_SEC (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {isScatter, isChase, isFright, fright_flash, reverse, phase}
  function automatic logic [7:0] observe();
    return {bus.isScatter, bus.isChase, bus.isFright, bus.fright_flash, bus.reverse, bus.phase};
  endfunction

  function automatic logic [7:0] sch(input int p, input bit r);
    logic [2:0] ph;
    ph = 3'(p);
    return {~ph[0], ph[0], 1'b0, 1'b0, r, ph};
  endfunction

  function automatic logic [7:0] frt(input bit fl, input bit r, input int p);
    return {1'b0, 1'b0, 1'b1, fl, r, 3'(p)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.pellet = 1'b0;
    step();
    reset_n   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    reset_n    = 1'b0;
    bus.start  = 1'b1;
    bus.pause  = 1'b0;
    bus.pellet = 1'b1;
    step();
    step();
    obs = observe();
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("FAIL reset_state got=%b exp=%b", obs, 8'h00);
    end
    bus.start  = 1'b0;
    bus.pellet = 1'b0;
  endtask

  task automatic test_schedule();
    int durs[7] = '{8, 12, 8, 12, 4, 12, 4};
    int revs = 0;
    logic [7:0] obs, e;
    do_start();
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < durs[p]; k++) begin
        if (!(p == 0 && k == 0)) step();
        e = sch(p, (k == 0) && (p != 0));
        obs = observe();
        revs += int'(bus.reverse);
        checks++;
        if (obs !== e) begin
          fails++;
          $display("FAIL schedule cyc=%0d got=%b exp=%b", cyc, obs, e);
        end
      end
    end
    for (int k = 0; k <= 200; k++) begin
      step();
      e = sch(7, k == 0);
      obs = observe();
      revs += int'(bus.reverse);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL final_phase cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
    end
    checks++;
    if (revs != 7) begin
      fails++;
      $display("FAIL reverse_count got=%0d exp=7", revs);
    end
  endtask

  task automatic test_fright();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 29; c++) begin
      if (c > 1) step();
      bus.pellet = 1'b0;
      if (c <= 8)       e = sch(0, 0);
      else if (c <= 11) e = sch(1, c == 9);
      else if (c <= 19) e = frt(c >= 16, c == 12, 1);
      else if (c <= 28) e = sch(1, 0);
      else              e = sch(2, 1);
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL fright cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c == 11) bus.pellet = 1'b1;
    end
  endtask

  task automatic test_refresh();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) step();
      bus.pellet = 1'b0;
      if (c <= 8)       e = sch(0, 0);
      else if (c <= 11) e = sch(1, c == 9);
      else if (c <= 17) e = frt(c >= 16, c == 12, 1);
      else if (c <= 25) e = frt(c >= 22, 0, 1);
      else if (c <= 34) e = sch(1, 0);
      else              e = sch(2, 1);
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL refresh cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c == 11 || c == 17) bus.pellet = 1'b1;
    end
  endtask

  task automatic test_pellet_at_expiry();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 29; c++) begin
      if (c > 1) step();
      bus.pellet = 1'b0;
      if (c <= 8)       e = sch(0, 0);
      else if (c <= 16) e = frt(c >= 13, c == 9, 1);
      else if (c <= 28) e = sch(1, 0);
      else              e = sch(2, 1);
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pellet_at_expiry cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c == 8) bus.pellet = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 37; c++) begin
      if (c > 1) step();
      bus.pellet = 1'b0;
      if (c <= 8)       e = sch(0, 0);
      else if (c <= 11) e = sch(1, c == 9);
      else if (c <= 19) e = frt(c >= 16, c == 12, 1);
      else if (c <= 27) e = frt(c >= 24, 0, 1);
      else if (c <= 36) e = sch(1, 0);
      else              e = sch(2, 1);
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c == 11 || c == 19) bus.pellet = 1'b1;
    end
  endtask

  task automatic test_ignored();
    logic [7:0] obs;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.pellet = 1'b0;
    step();
    reset_n    = 1'b1;
    bus.pellet = 1'b1;
    step();
    bus.pellet = 1'b0;
    step();
    obs = observe();
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("FAIL pellet_in_idle got=%b exp=%b", obs, 8'h00);
    end
    bus.start = 1'b1;
    bus.pause = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    bus.pause = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("FAIL start_while_paused got=%b exp=%b", obs, 8'h00);
    end
  endtask

  task automatic test_pause();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 72; c++) begin
      if (c > 1) step();
      bus.pause  = 1'b0;
      bus.pellet = 1'b0;
      if (c <= 58)      e = sch(0, 0);
      else if (c <= 71) e = sch(1, c == 59);
      else              e = sch(2, 1);
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c >= 3 && c <= 52) bus.pause = 1'b1;
      if (c == 59) begin
        bus.pause  = 1'b1;
        bus.pellet = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_fright();
    logic [7:0] obs, e;
    do_start();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      bus.pellet = 1'b0;
      reset_n    = 1'b1;
      if (c <= 8)       e = sch(0, 0);
      else if (c <= 11) e = sch(1, c == 9);
      else if (c <= 14) e = frt(0, c == 12, 1);
      else              e = 8'h00;
      obs = observe();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_fright cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (c == 11) bus.pellet = 1'b1;
      if (c == 14) reset_n = 1'b0;
    end
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.pellet = 1'b0;
    test_reset();
    test_schedule();
    test_fright();
    test_refresh();
    test_pellet_at_expiry();
    test_back_to_back();
    test_ignored();
    test_pause();
    test_reset_mid_fright();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
